// File: rtl/chol_lower_2_if.sv
// Request/result bundle for chol_lower_2: packed P in, packed S out with status.
// Valid/ready semantics: there is no ready. P is taken on an enabled edge when
// P_valid=1 and busy=0; S/err are meaningful only while S_valid=1, which is a
// level held until the next accepted P_valid.
interface chol_lower_2_if;
  logic [95:0] P;
  logic        P_valid;
  logic [95:0] S;
  logic        S_valid;
  logic        err;
  logic        busy;
  logic [2:0]  state_dbg;

  modport master (
    output P, P_valid,
    input  S, S_valid, err, busy, state_dbg
  );

  modport slave (
    input  P, P_valid,
    output S, S_valid, err, busy, state_dbg
  );
endinterface

// File: rtl/chol_lower_2.sv
// 2x2 inverse-Cholesky factor: S = {1/L22, L21, 1/L11} in Q16.16, computed
// sequentially with one shared bit-serial square root and one shared divider.
module chol_lower_2 (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clk_en,
  chol_lower_2_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SQRT  = 3'd1,
    S_RECIP = 3'd2,
    S_L21   = 3'd3,
    S_SCHUR = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        pass_q, pass_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [47:0] sq_x_q, sq_x_d;
  logic [25:0] sq_r_q, sq_r_d;
  logic [23:0] sq_q_q, sq_q_d;
  logic [31:0] dv_r_q, dv_r_d;
  logic [31:0] dv_q_q, dv_q_d;
  logic [31:0] dv_l_q, dv_l_d;
  logic [31:0] p21_q, p21_d;
  logic [31:0] p22_q, p22_d;
  logic [95:0] s_q, s_d;
  logic        s_valid_q, s_valid_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  // Square root step: bring down two radicand bits, try subtracting 4q+1.
  logic [27:0] sq_shift, sq_trial, sq_diff;
  logic        sq_ge;
  logic [25:0] sq_r_nxt;
  logic [23:0] sq_q_nxt;

  assign sq_shift = {sq_r_q, sq_x_q[47:46]};
  assign sq_trial = {2'b00, sq_q_q, 2'b01};
  assign sq_ge    = (sq_shift >= sq_trial);
  assign sq_diff  = sq_shift - sq_trial;
  assign sq_r_nxt = sq_ge ? sq_diff[25:0] : sq_shift[25:0];
  assign sq_q_nxt = {sq_q_q[22:0], sq_ge};

  // Division step on 2^32 / L: remainder starts at 1 (the 2^32 bit), zeros shift in.
  logic [32:0] dv_shift, dv_diff;
  logic        dv_ge;
  logic [31:0] dv_r_nxt;
  logic [31:0] dv_q_nxt;

  assign dv_shift = {dv_r_q, 1'b0};
  assign dv_ge    = (dv_shift >= {1'b0, dv_l_q});
  assign dv_diff  = dv_shift - {1'b0, dv_l_q};
  assign dv_r_nxt = dv_ge ? dv_diff[31:0] : dv_shift[31:0];
  assign dv_q_nxt = {dv_q_q[30:0], dv_ge};

  // L21 = P21 * (1/L11), Q16.16 rescale by taking bits [47:16]; wraps on overflow.
  logic signed [63:0] l21_a, l21_b, l21_prod;
  assign l21_a    = {{32{p21_q[31]}}, p21_q};
  assign l21_b    = {{32{s_q[31]}}, s_q[31:0]};
  assign l21_prod = l21_a * l21_b;

  // Schur complement d = P22 - L21^2, wide enough that it cannot wrap.
  logic signed [63:0] l21_sq_a, l21_sq;
  logic signed [48:0] p22_ext, sq_ext, schur_d;
  logic               schur_pos;

  assign l21_sq_a  = {{32{s_q[63]}}, s_q[63:32]};
  assign l21_sq    = l21_sq_a * l21_sq_a;
  assign p22_ext   = {{17{p22_q[31]}}, p22_q};
  assign sq_ext    = {17'b0, l21_sq[47:16]};
  assign schur_d   = p22_ext - sq_ext;
  assign schur_pos = !schur_d[48] && (schur_d != 49'sd0);

  logic p11_nonpos;
  assign p11_nonpos = bus.P[31] || (bus.P[31:0] == 32'd0);

  logic unused_bits;
  assign unused_bits = ^{sq_diff[27:26], dv_diff[32], l21_prod[63:48], l21_prod[15:0],
                         l21_sq[63:48], l21_sq[15:0]};

  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    cnt_d     = cnt_q;
    sq_x_d    = sq_x_q;
    sq_r_d    = sq_r_q;
    sq_q_d    = sq_q_q;
    dv_r_d    = dv_r_q;
    dv_q_d    = dv_q_q;
    dv_l_d    = dv_l_q;
    p21_d     = p21_q;
    p22_d     = p22_q;
    s_d       = s_q;
    s_valid_d = s_valid_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.P_valid) begin
          p21_d     = bus.P[63:32];
          p22_d     = bus.P[95:64];
          s_d       = '0;
          s_valid_d = 1'b0;
          err_d     = 1'b0;
          pass_d    = 1'b0;
          cnt_d     = '0;
          if (p11_nonpos) begin
            err_d     = 1'b1;
            s_valid_d = 1'b1;
          end else begin
            sq_x_d  = {bus.P[31:0], 16'b0};
            sq_r_d  = '0;
            sq_q_d  = '0;
            state_d = S_SQRT;
          end
        end
      end

      S_SQRT: begin
        sq_x_d = {sq_x_q[45:0], 2'b00};
        sq_r_d = sq_r_nxt;
        sq_q_d = sq_q_nxt;
        if (cnt_q == 5'd23) begin
          // Hand the finished root straight to the divider.
          cnt_d   = '0;
          dv_l_d  = {8'b0, sq_q_nxt};
          dv_r_d  = 32'd1;
          dv_q_d  = '0;
          state_d = S_RECIP;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_RECIP: begin
        dv_r_d = dv_r_nxt;
        dv_q_d = dv_q_nxt;
        if (cnt_q == 5'd31) begin
          cnt_d = '0;
          if (!pass_q) begin
            s_d[31:0] = dv_q_nxt;
            state_d   = S_L21;
          end else begin
            s_d[95:64] = dv_q_nxt;
            s_valid_d  = 1'b1;
            state_d    = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_L21: begin
        s_d[63:32] = l21_prod[47:16];
        state_d    = S_SCHUR;
      end

      S_SCHUR: begin
        if (!schur_pos) begin
          s_d       = '0;
          err_d     = 1'b1;
          s_valid_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          sq_x_d  = {schur_d[31:0], 16'b0};
          sq_r_d  = '0;
          sq_q_d  = '0;
          pass_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_SQRT;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pass_q    <= 1'b0;
      cnt_q     <= '0;
      sq_x_q    <= '0;
      sq_r_q    <= '0;
      sq_q_q    <= '0;
      dv_r_q    <= '0;
      dv_q_q    <= '0;
      dv_l_q    <= '0;
      p21_q     <= '0;
      p22_q     <= '0;
      s_q       <= '0;
      s_valid_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else if (clk_en) begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      cnt_q     <= cnt_d;
      sq_x_q    <= sq_x_d;
      sq_r_q    <= sq_r_d;
      sq_q_q    <= sq_q_d;
      dv_r_q    <= dv_r_d;
      dv_q_q    <= dv_q_d;
      dv_l_q    <= dv_l_d;
      p21_q     <= p21_d;
      p22_q     <= p22_d;
      s_q       <= s_d;
      s_valid_q <= s_valid_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.S         = s_q;
  assign bus.S_valid   = s_valid_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.state_dbg = state_q;

endmodule

// File: doc/chol_lower_2.md
# chol_lower_2

Computes the 2x2 "Inverse-Cholesky" factor of a symmetric positive-definite matrix P and emits it in the packed 96-bit S format consumed by `inv_lower_2`. The output is the lower Cholesky factor L of P with each diagonal term replaced by its reciprocal. It sits upstream of the triangular inverter in the sigma-point covariance path. Arithmetic is sequential and bit-serial: one shared restoring square-root unit and one shared restoring reciprocal unit.

## Interface
- No parameters. All values are signed Q16.16, 32 bits.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clk_en`  in  1  when low, all state, counters and outputs hold.
- `P`  in  96  [31:0]=P11, [63:32]=P21, [95:64]=P22.
- `P_valid`  in  1  sampled only in S_IDLE with clk_en high.
- `S`  out  96  [31:0]=1/L11, [63:32]=L21, [95:64]=1/L22.
- `S_valid`  out  1  result valid. Level signal: held until the next accepted P_valid.
- `err`  out  1  non-positive pivot detected. Valid with S_valid.
- `busy`  out  1  high in every state except S_IDLE.

## Operation
- Reset values: S=0, S_valid=0, err=0, busy=0, state S_IDLE, all counters 0.
- States: S_IDLE, S_SQRT, S_RECIP, S_L21, S_SCHUR. A pass bit (0/1) selects the pivot.
- Accept (S_IDLE, P_valid=1):
  - Capture P; clear S_valid, S and err; pass=0.
  - If P11<=0: set S=0, err=1, S_valid=1, stay in S_IDLE.
  - Otherwise go to S_SQRT with radicand = P11.
- S_SQRT:
  - 24 iterations of restoring integer square root on the 48-bit value {radicand,16'b0}. Gives floor(sqrt) = L in Q16.16, one iteration per cycle.
  - Then go to S_RECIP.
- S_RECIP:
  - 32 iterations of restoring division giving floor(2^32 / L).
  - A positive radicand guarantees L>=256, so the quotient is below 2^25 and never saturates.
  - Pass 0: S[31:0] <= quotient, go to S_L21.
  - Pass 1: S[95:64] <= quotient, S_valid<=1, go to S_IDLE.
- S_L21: L21 = bits [47:16] of the 64-bit signed product P21 * (1/L11). Truncation wraps. Store in S[63:32], go to S_SCHUR.
- S_SCHUR:
  - d = P22 - bits [47:16] of L21*L21, computed in 49-bit signed arithmetic.
  - If d<=0: S=0, err=1, S_valid=1, go to S_IDLE.
  - Otherwise radicand=d, pass=1, go to S_SQRT.
- P_valid outside S_IDLE is ignored, with no queueing.
- S is not guaranteed stable while busy=1. Consumers sample only when S_valid=1.

## Timing
- Latencies are counted in enabled edges. Edge 0 is the edge that accepts P.
- P11<=0 error: S_valid=1 after edge 0.
- Normal path:
  - S_SQRT: edges 1–24.
  - S_RECIP: edges 25–56.
  - S_L21: edge 57.
  - S_SCHUR: edge 58.
  - S_SQRT: edges 59–82.
  - S_RECIP: edges 83–114.
  - S_valid=1 and busy=0 after edge 114. Total latency is 114 enabled edges.
- Schur error: S_valid=1 and err=1 after edge 58.
- Each low cycle of clk_en extends latency by exactly one cycle.
- A new P is accepted on the first enabled edge in S_IDLE with P_valid=1, so back-to-back throughput is 115 cycles.
- rst_n low at any time immediately returns all outputs to reset values. Any in-flight computation is discarded.

## Test plan
- P11=0x00040000, P21=0x00020000, P22=0x00050000 -> S={0x00008000,0x00010000,0x00008000}, err=0, S_valid rises after edge 114.
- Identity: P11=P22=0x00010000, P21=0 -> S={0x00010000,0x00000000,0x00010000}, err=0.
- P11=0 -> S=0, err=1, S_valid after edge 0. P11=0xFFFF0000 gives the same result.
- Schur error: P11=P21=P22=0x00010000 -> d=0, so S=0, err=1, S_valid after edge 58.
- Run the first case with clk_en held low for 10 cycles mid-op -> identical S, S_valid after 124 cycles. A second P_valid pulse at edge 30 is ignored and the result is unchanged.
- Deassert rst_n at edge 40 -> S=0, S_valid=0, busy=0 immediately. After release, a fresh request completes normally in 114 edges.
